mul_issue_ctrl: RTL and testbench
=================================

# mul_issue_ctrl

Issue/writeback controller directly upstream of the multi-cycle M-extension multiplier `mul`. Accepts MUL/MULH/MULHSU/MULHU requests from the execute stage, registers the operands, and drives the multiplier's `start`/`done` handshake. It returns the 32-bit result to writeback with the destination register tag and stalls the pipeline while busy. A single-entry result cache returns repeated identical requests in one cycle without starting the multiplier.

## Interface
- `XLEN`, 32: operand/result width.
- `TIMEOUT`, 15: maximum BUSY cycles waiting for `mul_done` before abort.

- `clk` in 1: clock.
- `rst_n` in 1: reset; one clock; reset is synchronous and active-low.
- `in_valid` in 1: execute-stage request valid.
- `in_ready` out 1: request accepted when `in_valid & in_ready`.
- `in_funct3` in 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
- `in_rs1`, `in_rs2` in XLEN: operands.
- `in_rd` in 5: destination tag.
- `flush` in 1: pipeline kill.
- `mul_start` out 1: multiplier start, level.
- `mul_op` out 3: multiplier op.
- `mul_op1`, `mul_op2` out XLEN: multiplier operands.
- `mul_result` in XLEN: multiplier result, valid while `mul_done`.
- `mul_done` in 1: multiplier done.
- `wb_valid` out 1: one-cycle writeback pulse.
- `wb_rd` out 5: writeback tag.
- `wb_data` out XLEN: writeback data.
- `busy` out 1: stall request to the pipeline.
- `err_timeout` out 1: one-cycle pulse on abort.
- `err_illegal` out 1: one-cycle pulse on a request with `in_funct3[2]=1`.

## Operation
- States: IDLE, BUSY, GAP.
- `in_ready` = (state==IDLE) & ~flush. `busy` = state!=IDLE.
- IDLE, accept, `in_funct3[2]=1`: request is dropped. `err_illegal` pulses next cycle. No writeback. Stay in IDLE.
- IDLE, accept, cache hit (cache valid and funct3/rs1/rs2 equal): `wb_valid`/`wb_rd`/`wb_data` = cached values next cycle. Stay in IDLE, so back-to-back hits run at one per cycle.
- IDLE, accept, miss: register funct3/rs1/rs2/rd and go to BUSY.
- BUSY: `mul_start`=1. `mul_op`/`mul_op1`/`mul_op2` come from the registered copies and stay stable for the whole state.
  - `mul_done`: capture `mul_result`, update the cache, go to GAP.
  - `flush` (wins over `mul_done` in the same cycle): discard the result, leave the cache unchanged, go to GAP.
  - Timeout counter reaches `TIMEOUT` without `mul_done`: pulse `err_timeout`, go to GAP, no writeback.
- GAP: `mul_start`=0 so the multiplier's internal counter clears. `wb_valid` pulses here only for a normal completion. `flush` in GAP does not suppress that pulse. Always go to IDLE.
- Cache: one entry of funct3, rs1, rs2, data, valid. Invalidated only by reset. Not touched by flush or timeout.
- Reset (`rst_n` low at any edge, including mid-BUSY):
  - state IDLE, cache invalid, timeout counter 0.
  - All outputs 0 except `in_ready`, which follows its IDLE equation from the first cycle after reset.

## Timing
- Miss, accepted at edge T: BUSY from T+1 with `mul_start`=1.
  - With `mul`, `mul_done` arrives at T+3.
  - GAP at T+4 with `wb_valid`=1.
  - IDLE at T+5, `in_ready`=1; the next miss is accepted at T+5.
- Hit: `wb_valid` at T+1.
- All outputs are registered except `in_ready` and `busy`.
- `mul_start` is never high in two consecutive operations without an intervening low cycle.
- The timeout counter clears on entry to BUSY. Abort happens on the cycle the counter equals `TIMEOUT` (`TIMEOUT` = 15 means the 15th BUSY cycle).

## Structure
- Shared package `mext_pkg`: funct3 constants `F3_MUL`, `F3_MULH`, `F3_MULHSU`, `F3_MULHU` (values matching the multiplier's op encoding) and the state enum.
- One sub-module, `mul_result_cache`, holding the single entry:
  - inputs: lookup key, update strobe and data, synchronous clear;
  - output: `hit`.
- The FSM, operand registers and timeout counter stay in the top module.

## Test plan
- MUL, rs1=7, rs2=6, rd=5, with `mul` attached → `wb_valid` at T+4, `wb_rd`=5, `wb_data`=42; `mul_start` high exactly during T+1..T+3.
- MULH, rs1=0xFFFFFFFE (-2), rs2=3 → `wb_data`=0xFFFFFFFF. MULHU, 0xFFFFFFFF×0xFFFFFFFF → `wb_data`=0xFFFFFFFE.
- Repeat MULHU 0xFFFFFFFF×0xFFFFFFFF three times back-to-back → three `wb_valid` pulses at T+1, T+2, T+3, `mul_start` stays 0. Then MUL with the same operands → miss, `mul_start` rises, `wb_data`=0x00000001.
- `flush` in the second BUSY cycle of MUL 3×4 → no `wb_valid`, GAP, IDLE; next MUL 3×4 is a miss and returns 12.
- Stub that never asserts `mul_done`, TIMEOUT=15 → `err_timeout` pulses once after 15 BUSY cycles, no writeback, `mul_start` low in GAP, `in_ready` high the cycle after.
- `rst_n` low for one cycle mid-BUSY → next cycle: IDLE, `mul_start`=0, `wb_valid`=0; a previously cached request now misses. Also: `in_funct3`=100 → `err_illegal` pulse, no writeback, no `mul_start`.

Source files
------------

// File: rtl/mext_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mext_pkg
// Description : Shared M-extension constants and the issue-controller state
//               encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mext_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } mul_state_e;

    // Only the four multiply encodings have funct3[2] clear.
    function automatic logic f3_is_mul(input logic [2:0] f3);
        return ~f3[2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mul_issue_ctrl_if
// Description : Execute-stage request, multiplier handshake and writeback
//               bundle for the multiply issue controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface mul_issue_ctrl_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_funct3;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;
    logic [4:0]      in_rd;
    logic            flush;
    logic            mul_start;
    logic [2:0]      mul_op;
    logic [XLEN-1:0] mul_op1;
    logic [XLEN-1:0] mul_op2;
    logic [XLEN-1:0] mul_result;
    logic            mul_done;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            busy;
    logic            err_timeout;
    logic            err_illegal;

    modport master (
        output in_valid, in_funct3, in_rs1, in_rs2, in_rd, flush,
               mul_result, mul_done,
        input  in_ready, mul_start, mul_op, mul_op1, mul_op2,
               wb_valid, wb_rd, wb_data, busy, err_timeout, err_illegal
    );

    modport slave (
        input  in_valid, in_funct3, in_rs1, in_rs2, in_rd, flush,
               mul_result, mul_done,
        output in_ready, mul_start, mul_op, mul_op1, mul_op2,
               wb_valid, wb_rd, wb_data, busy, err_timeout, err_illegal
    );
endinterface
`default_nettype wire

// File: rtl/mul_result_cache.sv
`default_nettype none
// ============================================================================
// Module      : mul_result_cache
// Description : Single-entry cache of the last completed multiply, keyed on
//               funct3 and both operands.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_result_cache #(
    parameter int XLEN = 32
) (
    input  wire logic            clk,
    input  wire logic            clr,
    input  wire logic [2:0]      key_funct3,
    input  wire logic [XLEN-1:0] key_rs1,
    input  wire logic [XLEN-1:0] key_rs2,
    input  wire logic            upd,
    input  wire logic [2:0]      upd_funct3,
    input  wire logic [XLEN-1:0] upd_rs1,
    input  wire logic [XLEN-1:0] upd_rs2,
    input  wire logic [XLEN-1:0] upd_data,
    output logic                 hit,
    output logic [XLEN-1:0]      data
);
    logic            r_valid;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;
    logic [XLEN-1:0] r_data;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_valid  <= 1'b0;
            r_funct3 <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_data   <= '0;
        end else if (upd) begin
            r_valid  <= 1'b1;
            r_funct3 <= upd_funct3;
            r_rs1    <= upd_rs1;
            r_rs2    <= upd_rs2;
            r_data   <= upd_data;
        end
    end

    assign hit  = r_valid && (r_funct3 == key_funct3) &&
                  (r_rs1 == key_rs1) && (r_rs2 == key_rs2);
    assign data = r_data;

endmodule
`default_nettype wire

// File: rtl/mul_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mul_issue_ctrl
// Description : Issue/writeback controller in front of the multi-cycle
//               multiplier, with a single-entry result cache.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_issue_ctrl
    import mext_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 15
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    mul_issue_ctrl_if.slave bus
);
    localparam int             c_CW       = $clog2(TIMEOUT + 1);
    localparam logic [c_CW-1:0] c_TMO_LAST = c_CW'(TIMEOUT - 1);

    mul_state_e      r_state;
    mul_state_e      w_state_nxt;
    logic [c_CW-1:0] r_cnt;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;
    logic [4:0]      r_rd;
    logic            r_mul_start;
    logic            r_wb_valid;
    logic [4:0]      r_wb_rd;
    logic [XLEN-1:0] r_wb_data;
    logic            r_err_timeout;
    logic            r_err_illegal;

    logic            w_accept;
    logic            w_hit;
    logic [XLEN-1:0] w_cache_data;
    logic            w_illegal;
    logic            w_hit_wb;
    logic            w_miss;
    logic            w_done_ok;
    logic            w_tmo_fire;

    assign bus.in_ready = (r_state == ST_IDLE) & ~bus.flush;
    assign bus.busy     = (r_state != ST_IDLE);
    assign w_accept     = bus.in_valid & bus.in_ready;

    mul_result_cache #(.XLEN(XLEN)) u_cache (
        .clk        (clk),
        .clr        (~rst_n),
        .key_funct3 (bus.in_funct3),
        .key_rs1    (bus.in_rs1),
        .key_rs2    (bus.in_rs2),
        .upd        (w_done_ok),
        .upd_funct3 (r_funct3),
        .upd_rs1    (r_rs1),
        .upd_rs2    (r_rs2),
        .upd_data   (bus.mul_result),
        .hit        (w_hit),
        .data       (w_cache_data)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_illegal   = 1'b0;
        w_hit_wb    = 1'b0;
        w_miss      = 1'b0;
        w_done_ok   = 1'b0;
        w_tmo_fire  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (!f3_is_mul(bus.in_funct3)) begin
                        w_illegal = 1'b1;
                    end else if (w_hit) begin
                        w_hit_wb = 1'b1;
                    end else begin
                        w_miss      = 1'b1;
                        w_state_nxt = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                // Flush beats a same-cycle done; done beats the timeout.
                if (bus.flush) begin
                    w_state_nxt = ST_GAP;
                end else if (bus.mul_done) begin
                    w_done_ok   = 1'b1;
                    w_state_nxt = ST_GAP;
                end else if (r_cnt == c_TMO_LAST) begin
                    w_tmo_fire  = 1'b1;
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_funct3      <= '0;
            r_rs1         <= '0;
            r_rs2         <= '0;
            r_rd          <= '0;
            r_mul_start   <= 1'b0;
            r_wb_valid    <= 1'b0;
            r_wb_rd       <= '0;
            r_wb_data     <= '0;
            r_err_timeout <= 1'b0;
            r_err_illegal <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_mul_start   <= (w_state_nxt == ST_BUSY);
            r_wb_valid    <= w_hit_wb | w_done_ok;
            r_err_timeout <= w_tmo_fire;
            r_err_illegal <= w_illegal;
            if (w_hit_wb) begin
                r_wb_rd   <= bus.in_rd;
                r_wb_data <= w_cache_data;
            end else if (w_done_ok) begin
                r_wb_rd   <= r_rd;
                r_wb_data <= bus.mul_result;
            end
            if (w_miss) begin
                r_funct3 <= bus.in_funct3;
                r_rs1    <= bus.in_rs1;
                r_rs2    <= bus.in_rs2;
                r_rd     <= bus.in_rd;
                r_cnt    <= '0;
            end else if (r_state == ST_BUSY) begin
                r_cnt <= r_cnt + c_CW'(1);
            end
        end
    end

    assign bus.mul_start   = r_mul_start;
    assign bus.mul_op      = r_funct3;
    assign bus.mul_op1     = r_rs1;
    assign bus.mul_op2     = r_rs2;
    assign bus.wb_valid    = r_wb_valid;
    assign bus.wb_rd       = r_wb_rd;
    assign bus.wb_data     = r_wb_data;
    assign bus.err_timeout = r_err_timeout;
    assign bus.err_illegal = r_err_illegal;

endmodule
`default_nettype wire

// File: tb/tb_mul_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_issue_ctrl
// Description : Directed bench for mul_issue_ctrl with a behavioural
//               three-cycle multiplier that can be told never to finish.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_issue_ctrl;
    import mext_pkg::*;

    logic clk;
    logic rst_n;
    logic stub_hang;
    logic [1:0] r_mcnt;
    logic [63:0] w_pss, w_psu, w_puu;
    int n_tests;
    int n_fail;

    mul_issue_ctrl_if #(.XLEN(32)) bus ();

    mul_issue_ctrl #(.XLEN(32), .TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: done in the third consecutive start-high cycle.
    always @(posedge clk) begin
        if (!bus.mul_start) r_mcnt <= 2'd0;
        else if (r_mcnt != 2'd3) r_mcnt <= r_mcnt + 2'd1;
    end
    assign w_pss = {{32{bus.mul_op1[31]}}, bus.mul_op1} * {{32{bus.mul_op2[31]}}, bus.mul_op2};
    assign w_psu = {{32{bus.mul_op1[31]}}, bus.mul_op1} * {32'd0, bus.mul_op2};
    assign w_puu = {32'd0, bus.mul_op1} * {32'd0, bus.mul_op2};
    assign bus.mul_done   = bus.mul_start && (r_mcnt == 2'd2) && !stub_hang;
    assign bus.mul_result = (bus.mul_op == F3_MUL)    ? w_pss[31:0]  :
                            (bus.mul_op == F3_MULH)   ? w_pss[63:32] :
                            (bus.mul_op == F3_MULHSU) ? w_psu[63:32] : w_puu[63:32];

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Presents one request for one edge; returns at the negedge of cycle T+1.
    task automatic start_req(input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] rd);
        bus.in_valid  = 1'b1;
        bus.in_funct3 = f3;
        bus.in_rs1    = a;
        bus.in_rs2    = b;
        bus.in_rd     = rd;
        tick();
        bus.in_valid  = 1'b0;
    endtask

    task automatic run_miss(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
        start_req(f3, a, b, rd);
        chk1({tag, " start T+1"}, bus.mul_start, 1'b1);
        chk1({tag, " busy T+1"}, bus.busy, 1'b1);
        tick();
        chk1({tag, " start T+2"}, bus.mul_start, 1'b1);
        tick();
        chk1({tag, " start T+3"}, bus.mul_start, 1'b1);
        chk1({tag, " wb T+3"}, bus.wb_valid, 1'b0);
        tick();
        chk1({tag, " wb_valid T+4"}, bus.wb_valid, 1'b1);
        chk32({tag, " wb_rd"}, {27'd0, bus.wb_rd}, {27'd0, rd});
        chk32({tag, " wb_data"}, bus.wb_data, exp);
        chk1({tag, " start GAP"}, bus.mul_start, 1'b0);
        tick();
        chk1({tag, " in_ready T+5"}, bus.in_ready, 1'b1);
        chk1({tag, " wb T+5"}, bus.wb_valid, 1'b0);
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        stub_hang     = 1'b0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_funct3 = 3'd0;
        bus.in_rs1    = 32'd0;
        bus.in_rs2    = 32'd0;
        bus.in_rd     = 5'd0;
        bus.flush     = 1'b0;
        tick();
        tick();
        chk1("rst busy", bus.busy, 1'b0);
        chk1("rst mul_start", bus.mul_start, 1'b0);
        chk1("rst wb_valid", bus.wb_valid, 1'b0);
        chk1("rst err_timeout", bus.err_timeout, 1'b0);
        chk1("rst in_ready", bus.in_ready, 1'b1);
        rst_n = 1'b1;
        tick();

        // MUL 7*6 with operand check in the first BUSY cycle.
        start_req(F3_MUL, 32'd7, 32'd6, 5'd5);
        chk32("mul op1", bus.mul_op1, 32'd7);
        chk32("mul op2", bus.mul_op2, 32'd6);
        chk1("mul in_ready busy", bus.in_ready, 1'b0);
        tick();
        tick();
        chk1("mul start T+3", bus.mul_start, 1'b1);
        tick();
        chk1("mul wb_valid", bus.wb_valid, 1'b1);
        chk32("mul wb_rd", {27'd0, bus.wb_rd}, 32'd5);
        chk32("mul wb_data", bus.wb_data, 32'd42);
        tick();
        chk1("mul in_ready", bus.in_ready, 1'b1);

        run_miss("mulh", F3_MULH, 32'hFFFF_FFFE, 32'd3, 5'd6, 32'hFFFF_FFFF);
        run_miss("mulhu", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE);

        // Three back-to-back cache hits.
        bus.in_valid  = 1'b1;
        bus.in_funct3 = F3_MULHU;
        bus.in_rs1    = 32'hFFFF_FFFF;
        bus.in_rs2    = 32'hFFFF_FFFF;
        bus.in_rd     = 5'd4;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("hit wb_valid", bus.wb_valid, 1'b1);
            chk32("hit wb_data", bus.wb_data, 32'hFFFF_FFFE);
            chk32("hit wb_rd", {27'd0, bus.wb_rd}, 32'd4);
            chk1("hit mul_start", bus.mul_start, 1'b0);
            chk1("hit busy", bus.busy, 1'b0);
            if (i == 2) bus.in_valid = 1'b0;
        end
        tick();
        chk1("hit end wb_valid", bus.wb_valid, 1'b0);
        run_miss("mul after hits", F3_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'h0000_0001);

        // Flush in the second BUSY cycle.
        start_req(F3_MUL, 32'd3, 32'd4, 5'd7);
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk1("flush gap busy", bus.busy, 1'b1);
        chk1("flush gap start", bus.mul_start, 1'b0);
        chk1("flush gap wb", bus.wb_valid, 1'b0);
        tick();
        chk1("flush idle ready", bus.in_ready, 1'b1);
        chk1("flush idle wb", bus.wb_valid, 1'b0);
        run_miss("mul after flush", F3_MUL, 32'd3, 32'd4, 5'd7, 32'd12);

        // Hung multiplier: abort after the 15th BUSY cycle.
        stub_hang = 1'b1;
        start_req(F3_MULHU, 32'd5, 32'd5, 5'd9);
        for (int k = 1; k <= 15; k++) begin
            chk1("tmo start", bus.mul_start, 1'b1);
            chk1("tmo early", bus.err_timeout, 1'b0);
            if (k < 15) tick();
        end
        tick();
        chk1("tmo pulse", bus.err_timeout, 1'b1);
        chk1("tmo wb", bus.wb_valid, 1'b0);
        chk1("tmo gap start", bus.mul_start, 1'b0);
        tick();
        chk1("tmo ready", bus.in_ready, 1'b1);
        chk1("tmo pulse end", bus.err_timeout, 1'b0);
        stub_hang = 1'b0;

        // Reset mid-BUSY clears the cached MUL 3*4 entry.
        start_req(F3_MUL, 32'd2, 32'd2, 5'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk1("midrst busy", bus.busy, 1'b0);
        chk1("midrst start", bus.mul_start, 1'b0);
        chk1("midrst wb", bus.wb_valid, 1'b0);
        chk1("midrst ready", bus.in_ready, 1'b1);
        run_miss("post-reset miss", F3_MUL, 32'd3, 32'd4, 5'd7, 32'd12);

        // Illegal funct3.
        start_req(3'b100, 32'd1, 32'd1, 5'd2);
        chk1("illegal pulse", bus.err_illegal, 1'b1);
        chk1("illegal wb", bus.wb_valid, 1'b0);
        chk1("illegal start", bus.mul_start, 1'b0);
        chk1("illegal busy", bus.busy, 1'b0);
        tick();
        chk1("illegal pulse end", bus.err_illegal, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
